board_game_controller: RTL

Parametrised turn-based N×N "K-in-a-row" game engine, successor to the fixed 3×3 tic-tac-toe logic feeding video_controller. Accepts moves over a valid/ready handshake and validates them. Alternates players X/O, sequentially checks for a win around the last placed cell, and detects a draw. Exposes the flattened board and game status for the VGA sprite path.

---
 rtl/game_pkg.sv | 32 +++
 rtl/win_checker.sv | 115 +++++++++++
 rtl/board_game_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and direction constants for the K-in-a-row game engine.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PX    = 2'b01,
    PO    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_PLAYING  = 2'b00,
    ST_WIN      = 2'b01,
    ST_DRAW     = 2'b10,
    ST_CHECKING = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    OVER
  } fsm_t;

  // Walk order: horizontal, vertical, diagonal, anti-diagonal
  localparam int NUM_DIRS = 4;
  localparam int DIR_DR [NUM_DIRS] = '{0, 1, 1, 1};
  localparam int DIR_DC [NUM_DIRS] = '{1, 0, 1, -1};

  function automatic cell_t other_player(input cell_t p);
    return (p == PX) ? PO : PX;
  endfunction

endpackage

// File: rtl/win_checker.sv
// Sequential win search around the last placed cell, one cell per cycle.
module win_checker
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter int K_WIN = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_row,
  input  logic [IDX_W-1:0] i_col,
  input  cell_t            i_player,
  input  logic [2*N*N-1:0] i_board,
  output logic             o_done,
  output logic             o_win
);

  localparam int SW = 4;

  logic             r_busy;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  cell_t            r_player;
  logic [1:0]       r_dir;
  logic             r_side;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    r_run;

  logic [1:0]    w_dir_nxt;
  logic          w_side_nxt;
  logic [SW-1:0] w_step_nxt;
  logic [SW-1:0] w_run_nxt;
  int            w_r;
  int            w_c;
  logic          w_inb;
  logic [1:0]    w_cell;
  logic          w_match;

  // Probe the current cell, decide whether this side continues, flips or the direction ends
  always_comb begin
    w_dir_nxt  = r_dir;
    w_side_nxt = r_side;
    w_step_nxt = r_step;
    w_run_nxt  = r_run;
    o_done     = 1'b0;
    o_win      = 1'b0;
    w_r = int'(r_row) + (r_side ? -1 : 1) * DIR_DR[r_dir] * int'(r_step);
    w_c = int'(r_col) + (r_side ? -1 : 1) * DIR_DC[r_dir] * int'(r_step);
    w_inb = (w_r >= 0) && (w_r < N) && (w_c >= 0) && (w_c < N);
    w_cell = EMPTY;
    for (int unsigned i = 0; i < N * N; i++) begin
      if (w_inb && (i == unsigned'(w_r * N + w_c))) w_cell = i_board[2*i +: 2];
    end
    w_match = r_busy && w_inb && (w_cell == r_player);
    if (r_busy) begin
      // Run is monotonic, so testing on every match lets a win end the walk immediately
      if (w_match && (int'(r_run) + 2 >= K_WIN)) begin
        o_done = 1'b1;
        o_win  = 1'b1;
      end else if (w_match && (int'(r_step) < K_WIN - 1)) begin
        w_step_nxt = r_step + SW'(1);
        w_run_nxt  = r_run + SW'(1);
      end else begin
        if (w_match) w_run_nxt = r_run + SW'(1);
        if (!r_side) begin
          w_side_nxt = 1'b1;
          w_step_nxt = SW'(1);
        end else if (r_dir == 2'(NUM_DIRS - 1)) begin
          o_done = 1'b1;
        end else begin
          w_dir_nxt  = r_dir + 2'd1;
          w_side_nxt = 1'b0;
          w_step_nxt = SW'(1);
          w_run_nxt  = '0;
        end
      end
    end
  end

  // Walk registers: latch origin on start, advance while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_player <= PX;
      r_dir    <= '0;
      r_side   <= 1'b0;
      r_step   <= SW'(1);
      r_run    <= '0;
    end else if (i_clear) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_row    <= i_row;
      r_col    <= i_col;
      r_player <= i_player;
      r_dir    <= '0;
      r_side   <= 1'b0;
      r_step   <= SW'(1);
      r_run    <= '0;
    end else if (o_done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_dir  <= w_dir_nxt;
      r_side <= w_side_nxt;
      r_step <= w_step_nxt;
      r_run  <= w_run_nxt;
    end
  end

endmodule

// File: rtl/board_game_controller.sv
// N x N K-in-a-row engine: move handshake, board, turns, win/draw status.
module board_game_controller
  import game_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int K_WIN = 3,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N * N + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [IDX_W-1:0] move_row,
  input  logic [IDX_W-1:0] move_col,
  output logic             move_ready,
  output logic             move_reject,
  output logic [2*N*N-1:0] board,
  output logic [1:0]       cur_player,
  output logic [1:0]       status,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] move_count
);

  fsm_t             r_state,  w_state_nxt;
  logic [2*N*N-1:0] r_board,  w_board_nxt;
  cell_t            r_player, w_player_nxt;
  status_t          r_status, w_status_nxt;
  cell_t            r_winner, w_winner_nxt;
  logic [CNT_W-1:0] r_count,  w_count_nxt;
  logic             r_reject, w_reject_nxt;

  logic        w_start;
  logic        w_legal;
  logic [1:0]  w_target;
  int unsigned w_idx;
  logic        w_done;
  logic        w_win;

  win_checker #(
    .N    (N),
    .K_WIN(K_WIN),
    .IDX_W(IDX_W)
  ) u_win_checker (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_clear (new_game),
    .i_start (w_start),
    .i_row   (move_row),
    .i_col   (move_col),
    .i_player(r_player),
    .i_board (r_board),
    .o_done  (w_done),
    .o_win   (w_win)
  );

  // Next-state, move validation and end-of-check resolution
  always_comb begin
    w_state_nxt  = r_state;
    w_board_nxt  = r_board;
    w_player_nxt = r_player;
    w_status_nxt = r_status;
    w_winner_nxt = r_winner;
    w_count_nxt  = r_count;
    w_reject_nxt = 1'b0;
    w_start      = 1'b0;
    w_idx    = unsigned'(int'(move_row) * N + int'(move_col));
    w_target = EMPTY;
    for (int unsigned i = 0; i < N * N; i++) begin
      if (i == w_idx) w_target = r_board[2*i +: 2];
    end
    w_legal = (int'(move_row) < N) && (int'(move_col) < N) && (w_target == EMPTY);
    if (new_game) begin
      w_state_nxt  = PLAY;
      w_board_nxt  = '0;
      w_player_nxt = PX;
      w_status_nxt = ST_PLAYING;
      w_winner_nxt = EMPTY;
      w_count_nxt  = '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (move_valid) begin
            if (!w_legal) begin
              w_reject_nxt = 1'b1;
            end else begin
              for (int unsigned i = 0; i < N * N; i++) begin
                if (i == w_idx) w_board_nxt[2*i +: 2] = r_player;
              end
              w_count_nxt  = r_count + CNT_W'(1);
              w_start      = 1'b1;
              w_state_nxt  = CHECK;
              w_status_nxt = ST_CHECKING;
            end
          end
        end
        CHECK: begin
          if (w_done) begin
            if (w_win) begin
              w_winner_nxt = r_player;
              w_status_nxt = ST_WIN;
              w_state_nxt  = OVER;
            end else if (r_count == CNT_W'(N * N)) begin
              w_status_nxt = ST_DRAW;
              w_state_nxt  = OVER;
            end else begin
              w_player_nxt = other_player(r_player);
              w_status_nxt = ST_PLAYING;
              w_state_nxt  = PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= PLAY;
      r_board  <= '0;
      r_player <= PX;
      r_status <= ST_PLAYING;
      r_winner <= EMPTY;
      r_count  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_board  <= w_board_nxt;
      r_player <= w_player_nxt;
      r_status <= w_status_nxt;
      r_winner <= w_winner_nxt;
      r_count  <= w_count_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  assign move_ready  = (r_state == PLAY);
  assign move_reject = r_reject;
  assign board       = r_board;
  assign cur_player  = r_player;
  assign status      = r_status;
  assign winner      = r_winner;
  assign move_count  = r_count;

endmodule
